// File: rtl/rangen_param.sv
// Purpose : parametrised Galois-LFSR random source with a rejection-sampled range-limited draw port.
// Latency : Req accepted at cycle t -> Valid at t+2 at the earliest, t+1+MAX_TRIES at the latest.
// Backpr. : no queueing; Req is ignored while Busy=1, so the requester holds or re-issues Req.
//
// Ports
//   Clk, Reset      clock and synchronous active-high reset
//   Enable          free-run step of the LFSR while the draw FSM is idle
//   Seed_load/_in   load a new seed (zero is replaced by SEED)
//   Req, Range      draw request and its exclusive upper bound (sampled on accept)
//   Busy            draw in progress
//   Valid           one-cycle pulse; Rand_num holds the result until the next Valid
//   Lfsr_state      raw LFSR register
module rangen_param #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   TAPS      = 16'h6801,
    parameter logic [WIDTH-1:0]   SEED      = 16'h0065,
    parameter int                 OUT_W     = 8,
    parameter int                 MAX_TRIES = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Seed_load,
    input  logic [WIDTH-1:0] Seed_in,
    input  logic             Req,
    input  logic [OUT_W-1:0] Range,
    output logic             Busy,
    output logic             Valid,
    output logic [OUT_W-1:0] Rand_num,
    output logic [WIDTH-1:0] Lfsr_state
);

    // tries counts rejected candidates 0..MAX_TRIES-1; the last rejection
    // triggers the fallback instead of incrementing past the range.
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   lfsr, lfsr_nxt;
    logic [OUT_W-1:0]   range_q, range_nxt;
    logic [TRY_W-1:0]   tries, tries_nxt;
    logic [OUT_W-1:0]   rand_q, rand_nxt;
    logic               valid_q, valid_nxt;
    logic               step_en;
    logic [OUT_W-1:0]   cand;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : '0);
    endfunction

    // The candidate is the state before this cycle's step.
    assign cand = lfsr[OUT_W-1:0];

    always_comb begin
        state_nxt = state;
        range_nxt = range_q;
        tries_nxt = tries;
        rand_nxt  = rand_q;
        valid_nxt = 1'b0;
        step_en   = Enable;
        lfsr_nxt  = lfsr;

        case (state)
            IDLE: begin
                if (Req) begin
                    if (Range == '0) begin
                        // Empty range: answer immediately without entering DRAW.
                        rand_nxt  = '0;
                        valid_nxt = 1'b1;
                    end else begin
                        range_nxt = Range;
                        tries_nxt = '0;
                        state_nxt = DRAW;
                    end
                end
            end
            DRAW: begin
                step_en = 1'b1;
                if (cand < range_q) begin
                    rand_nxt  = cand;
                    valid_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (tries == LAST_TRY) begin
                    // Out of retries: return the top of the range so latency stays bounded.
                    rand_nxt  = range_q - OUT_W'(1);
                    valid_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tries_nxt = tries + TRY_W'(1);
                end
            end
        endcase

        if (Seed_load) begin
            lfsr_nxt = Seed_in;
        end else if (step_en) begin
            lfsr_nxt = lfsr_step(lfsr);
        end
        // An all-zero Galois LFSR never leaves zero; substitute the seed.
        if (lfsr_nxt == '0) begin
            lfsr_nxt = SEED;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            lfsr    <= SEED;
            range_q <= '0;
            tries   <= '0;
            rand_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            lfsr    <= lfsr_nxt;
            range_q <= range_nxt;
            tries   <= tries_nxt;
            rand_q  <= rand_nxt;
            valid_q <= valid_nxt;
        end
    end

    assign Busy       = (state == DRAW);
    assign Valid      = valid_q;
    assign Rand_num   = rand_q;
    assign Lfsr_state = lfsr;

endmodule

// File: tb/tb_rangen_param.sv
module tb_rangen_param;

    logic       Clk;
    logic       Reset;
    logic       Enable;
    logic       Seed_load;
    logic [7:0] Seed_in;
    logic       Req;
    logic [7:0] Range;

    logic       busy1, valid1, busy2, valid2;
    logic [7:0] rand1, lfsr1, rand2, lfsr2;

    int vectors;
    int miscompares;

    rangen_param #(.WIDTH(8), .TAPS(8'h71), .SEED(8'd101), .OUT_W(8), .MAX_TRIES(8)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Seed_load(Seed_load), .Seed_in(Seed_in),
        .Req(Req), .Range(Range), .Busy(busy1), .Valid(valid1), .Rand_num(rand1), .Lfsr_state(lfsr1)
    );

    rangen_param #(.WIDTH(8), .TAPS(8'h71), .SEED(8'd101), .OUT_W(8), .MAX_TRIES(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Seed_load(Seed_load), .Seed_in(Seed_in),
        .Req(Req), .Range(Range), .Busy(busy2), .Valid(valid2), .Rand_num(rand2), .Lfsr_state(lfsr2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: multiply-by-x in GF(2^8) modulo the legacy polynomial.
    function automatic int mstep(input int s);
        int n;
        n = s * 2;
        if (n >= 256) n = (n - 256) ^ 'h71;
        return n;
    endfunction

    // Reference draw: walk the sequence from the first candidate state.
    function automatic void model_draw(input int start, input int rg, input int maxt,
                                       output int val, output int lat);
        int s;
        s = start;
        if (rg == 0) begin
            val = 0;
            lat = 1;
            return;
        end
        for (int k = 1; k <= maxt; k++) begin
            if (s < rg) begin
                val = s;
                lat = k + 1;
                return;
            end
            s = mstep(s);
        end
        val = rg - 1;
        lat = maxt + 1;
    endfunction

    task automatic do_reset();
        Reset = 1'b1; Enable = 1'b0; Seed_load = 1'b0; Seed_in = 8'h00; Req = 1'b0; Range = 8'h00;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Enable = 1'b1; Req = 1'b1; Range = 8'd50; Seed_load = 1'b0; Seed_in = 8'h00;
        tick(); tick();
        Reset = 1'b0; Req = 1'b0; Enable = 1'b0;
        vectors++; if (lfsr1 !== 8'h65) begin miscompares++; $display("FAIL reset_lfsr: got %h want 65", lfsr1); end
        vectors++; if (rand1 !== 8'h00) begin miscompares++; $display("FAIL reset_rand: got %h want 00", rand1); end
        vectors++; if (valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid1); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy1); end
        vectors++; if (lfsr2 !== 8'h65) begin miscompares++; $display("FAIL reset_lfsr2: got %h want 65", lfsr2); end
        vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL reset_busy2: got %b want 0", busy2); end
    endtask

    task automatic test_step();
        logic [7:0] seq [4];
        int m;
        bit zero_seen;
        seq = '{8'h65, 8'hCA, 8'hE5, 8'hBB};
        do_reset();
        Enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) Enable = 1'b0;
            vectors++;
            if (lfsr1 !== seq[i]) begin miscompares++; $display("FAIL step_seq[%0d]: got %h want %h", i, lfsr1, seq[i]); end
            if (i < 3) tick();
        end
        tick(); tick();
        vectors++; if (lfsr1 !== 8'hBB) begin miscompares++; $display("FAIL step_hold: got %h want bb", lfsr1); end

        do_reset();
        m = 'h65;
        zero_seen = 1'b0;
        Enable = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            tick();
            m = mstep(m);
            if (lfsr1 == 8'h00) zero_seen = 1'b1;
            vectors++;
            if (lfsr1 !== m[7:0]) begin miscompares++; $display("FAIL freerun[%0d]: got %h want %h", k, lfsr1, m[7:0]); end
        end
        Enable = 1'b0;
        vectors++; if (lfsr1 !== 8'h65) begin miscompares++; $display("FAIL period: got %h want 65", lfsr1); end
        vectors++; if (zero_seen) begin miscompares++; $display("FAIL no_zero: got zero state, want none"); end
    endtask

    task automatic test_draw_basic();
        do_reset();
        Range = 8'd200; Req = 1'b1;
        tick();
        Req = 1'b0;
        vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL basic_busy_t1: got %b want 1", busy1); end
        vectors++; if (valid1 !== 1'b0) begin miscompares++; $display("FAIL basic_valid_t1: got %b want 0", valid1); end
        tick();
        vectors++; if (valid1 !== 1'b1) begin miscompares++; $display("FAIL basic_valid_t2: got %b want 1", valid1); end
        vectors++; if (rand1 !== 8'd101) begin miscompares++; $display("FAIL basic_rand: got %0d want 101", rand1); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL basic_busy_t2: got %b want 0", busy1); end
        vectors++; if (valid2 !== 1'b1 || rand2 !== 8'd101) begin miscompares++; $display("FAIL basic_dut2: got valid %b rand %0d want 1/101", valid2, rand2); end
        tick();
        vectors++; if (valid1 !== 1'b0) begin miscompares++; $display("FAIL basic_valid_t3: got %b want 0", valid1); end
    endtask

    task automatic test_reject();
        do_reset();
        Range = 8'd100; Req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            // a stray request at cycle 2 falls while both instances are busy
            Req   = (c == 2);
            Range = (c == 2) ? 8'd5 : 8'd100;
            vectors++;
            if (valid1 !== (c == 6)) begin miscompares++; $display("FAIL reject_valid t=%0d: got %b want %b", c, valid1, (c == 6)); end
            vectors++;
            if (valid2 !== (c == 3)) begin miscompares++; $display("FAIL fallback_valid t=%0d: got %b want %b", c, valid2, (c == 3)); end
            if (c <= 5) begin
                vectors++;
                if (busy1 !== 1'b1) begin miscompares++; $display("FAIL reject_busy t=%0d: got %b want 1", c, busy1); end
            end
            if (c == 6) begin
                vectors++;
                if (rand1 !== 8'd7) begin miscompares++; $display("FAIL reject_rand: got %0d want 7", rand1); end
            end
            if (c == 3) begin
                vectors++;
                if (rand2 !== 8'd99) begin miscompares++; $display("FAIL fallback_rand: got %0d want 99", rand2); end
            end
        end
        Req = 1'b0;
    endtask

    task automatic test_range_zero();
        Range = 8'd0; Req = 1'b1;
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL zero_busy_t0: got %b want 0", busy1); end
        tick();
        Req = 1'b0;
        vectors++; if (valid1 !== 1'b1) begin miscompares++; $display("FAIL zero_valid: got %b want 1", valid1); end
        vectors++; if (rand1 !== 8'd0) begin miscompares++; $display("FAIL zero_rand: got %0d want 0", rand1); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL zero_busy_t1: got %b want 0", busy1); end
        vectors++; if (rand2 !== 8'd0) begin miscompares++; $display("FAIL zero_rand2: got %0d want 0", rand2); end
        tick();
        vectors++; if (valid1 !== 1'b0) begin miscompares++; $display("FAIL zero_pulse: got %b want 0", valid1); end
    endtask

    task automatic test_seed();
        int vcount;
        do_reset();
        Enable = 1'b1;
        tick(); tick();
        Enable = 1'b0; Seed_load = 1'b1; Seed_in = 8'h00;
        tick();
        Seed_load = 1'b0;
        vectors++; if (lfsr1 !== 8'h65) begin miscompares++; $display("FAIL seed_zero: got %h want 65", lfsr1); end
        Seed_load = 1'b1; Seed_in = 8'h3C; Enable = 1'b1;
        tick();
        Seed_load = 1'b0; Enable = 1'b0;
        vectors++; if (lfsr1 !== 8'h3C) begin miscompares++; $display("FAIL seed_over_step: got %h want 3c", lfsr1); end

        do_reset();
        Range = 8'd1; Req = 1'b1;
        tick();
        Req = 1'b0;
        tick(); tick();
        vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL abort_busy_t3: got %b want 1", busy1); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        vectors++; if (lfsr1 !== 8'h65 || rand1 !== 8'h00 || valid1 !== 1'b0 || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_outputs: got lfsr %h rand %h valid %b busy %b want 65/00/0/0", lfsr1, rand1, valid1, busy1);
        end
        vectors++; if (rand2 !== 8'h00 || valid2 !== 1'b0 || busy2 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_outputs2: got rand %h valid %b busy %b want 00/0/0", rand2, valid2, busy2);
        end
        vcount = 0;
        for (int c = 0; c < 12; c++) begin
            if (valid1) vcount++;
            tick();
        end
        vectors++; if (vcount != 0) begin miscompares++; $display("FAIL abort_no_valid: got %0d pulses want 0", vcount); end
    endtask

    task automatic test_random();
        int m, sd, rg, sel;
        int ev1, el1, ev2, el2;
        int gv1, gl1, gv2, gl2, n1, n2;
        for (int it = 0; it < 40; it++) begin
            sd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            Seed_load = 1'b1; Seed_in = sd[7:0]; Enable = 1'($urandom_range(0, 1));
            tick();
            Seed_load = 1'b0;
            m = (sd == 0) ? 'h65 : sd;
            vectors++; if (lfsr1 !== m[7:0] || lfsr2 !== m[7:0]) begin
                miscompares++;
                $display("FAIL rnd_seed it=%0d: got %h/%h want %h", it, lfsr1, lfsr2, m[7:0]);
            end
            sel = $urandom_range(0, 7);
            rg = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 255 : int'($urandom_range(1, 255));
            Req = 1'b1; Range = rg[7:0]; Enable = 1'($urandom_range(0, 1));
            // idle stepping on the accept edge shifts the first candidate
            if (Enable) m = mstep(m);
            model_draw(m, rg, 8, ev1, el1);
            model_draw(m, rg, 2, ev2, el2);
            gl1 = -1; gl2 = -1; gv1 = -1; gv2 = -1; n1 = 0; n2 = 0;
            for (int c = 1; c <= 12; c++) begin
                tick();
                Req = 1'b0;
                Enable = 1'($urandom_range(0, 1));
                if (valid1) begin n1++; if (gl1 < 0) begin gl1 = c; gv1 = rand1; end end
                if (valid2) begin n2++; if (gl2 < 0) begin gl2 = c; gv2 = rand2; end end
            end
            Enable = 1'b0;
            vectors++; if (gl1 != el1 || gv1 != ev1 || n1 != 1) begin
                miscompares++;
                $display("FAIL rnd_draw it=%0d range=%0d: got val %0d lat %0d pulses %0d want val %0d lat %0d pulses 1", it, rg, gv1, gl1, n1, ev1, el1);
            end
            vectors++; if (gl2 != el2 || gv2 != ev2 || n2 != 1) begin
                miscompares++;
                $display("FAIL rnd_draw2 it=%0d range=%0d: got val %0d lat %0d pulses %0d want val %0d lat %0d pulses 1", it, rg, gv2, gl2, n2, ev2, el2);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        Reset = 1'b1; Enable = 1'b0; Seed_load = 1'b0; Seed_in = 8'h00; Req = 1'b0; Range = 8'h00;
        test_reset();
        test_step();
        test_draw_basic();
        test_reject();
        test_range_zero();
        test_seed();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
